// File: rtl/conv_result_collector.sv
// conv_result_collector
//   Collects the filtered pixel stream from the 3x3 convolution core into an
//   IMG_W x IMG_H frame buffer. When the buffer is full it pulses frame_done.
//   On dump_start it replays the frame in raster order over a valid/ready stream.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_pixel    filtered pixel input (raster order)
//   in_ready              high while the collector is filling
//   frame_done            one-cycle pulse after the last pixel of a frame is written
//   dump_start            replay request, honoured only while the buffer is full
//   out_valid, out_pixel  replay stream; out_last marks the final pixel
//   out_ready             downstream accept
//   ovf_err               sticky: a pixel was offered while not filling
module conv_result_collector #(
  parameter int DW    = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pixel,
  output logic          in_ready,
  output logic          frame_done,
  input  logic          dump_start,
  output logic          out_valid,
  output logic [DW-1:0] out_pixel,
  input  logic          out_ready,
  output logic          out_last,
  output logic          ovf_err
);

  localparam int            DEPTH = IMG_W * IMG_H;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_FILL, S_FULL, S_DUMP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_issued_q, rd_issued_d;   // every address of the frame has been read
  logic          rd_vld_q, rd_vld_d;         // rd_data_q holds a fresh memory word
  logic          rd_last_q, rd_last_d;
  logic [DW-1:0] rd_data_q;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_pixel_q, out_pixel_d;
  logic          out_last_q, out_last_d;
  logic          skid_vld_q, skid_vld_d;
  logic [DW-1:0] skid_pixel_q, skid_pixel_d;
  logic          skid_last_q, skid_last_d;
  logic          frame_done_q, frame_done_d;
  logic          ovf_err_q, ovf_err_d;

  logic          wr_beat;
  logic          pop;
  logic          issue;
  logic [1:0]    held;

  logic [DW-1:0] mem [DEPTH];

  // NOTE: every always_comb output is given its default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_issued_d  = rd_issued_q;
    rd_vld_d     = 1'b0;
    rd_last_d    = 1'b0;
    out_valid_d  = out_valid_q;
    out_pixel_d  = out_pixel_q;
    out_last_d   = out_last_q;
    skid_vld_d   = skid_vld_q;
    skid_pixel_d = skid_pixel_q;
    skid_last_d  = skid_last_q;
    frame_done_d = 1'b0;
    ovf_err_d    = ovf_err_q;

    wr_beat = (state_q == S_FILL) && in_valid;
    pop     = out_valid_q && out_ready;

    // Words held after this cycle (output + skid + one in flight). A new read is
    // issued only if the word it returns is guaranteed a slot next cycle.
    held  = 2'(out_valid_q) + 2'(skid_vld_q) + 2'(rd_vld_q) - 2'(pop);
    issue = (state_q == S_DUMP) && !rd_issued_q && (held < 2'd2);

    if (in_valid && (state_q != S_FILL)) ovf_err_d = 1'b1;

    unique case (state_q)
      S_FILL: begin
        if (wr_beat) begin
          if (wr_addr_q == LAST) begin
            wr_addr_d    = '0;
            state_d      = S_FULL;
            frame_done_d = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      S_FULL: begin
        if (dump_start) begin
          state_d     = S_DUMP;
          rd_addr_d   = '0;
          rd_issued_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (issue) begin
      rd_vld_d  = 1'b1;
      rd_last_d = (rd_addr_q == LAST);
      if (rd_addr_q == LAST) rd_issued_d = 1'b1;
      else                   rd_addr_d   = rd_addr_q + 1'b1;
    end

    // Output register reloads only when empty or transferring, so a stalled
    // pixel never changes. The skid register is older than rd_data and goes first.
    if (!out_valid_q || pop) begin
      if (skid_vld_q) begin
        out_valid_d  = 1'b1;
        out_pixel_d  = skid_pixel_q;
        out_last_d   = skid_last_q;
        skid_vld_d   = rd_vld_q;
        skid_pixel_d = rd_data_q;
        skid_last_d  = rd_last_q;
      end else if (rd_vld_q) begin
        out_valid_d = 1'b1;
        out_pixel_d = rd_data_q;
        out_last_d  = rd_last_q;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (rd_vld_q) begin
      skid_vld_d   = 1'b1;
      skid_pixel_d = rd_data_q;
      skid_last_d  = rd_last_q;
    end

    if (pop && out_last_q) begin
      state_d     = S_FILL;
      rd_addr_d   = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FILL;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      rd_issued_q  <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= '0;
      out_last_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_pixel_q <= '0;
      skid_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_issued_q  <= rd_issued_d;
      rd_vld_q     <= rd_vld_d;
      rd_last_q    <= rd_last_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      out_last_q   <= out_last_d;
      skid_vld_q   <= skid_vld_d;
      skid_pixel_q <= skid_pixel_d;
      skid_last_q  <= skid_last_d;
      frame_done_q <= frame_done_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  // NOTE: the frame buffer and its read register carry no reset so they map onto
  // block RAM; rd_vld_q qualifies rd_data_q.
  always_ff @(posedge clk) begin
    if (wr_beat) mem[wr_addr_q] <= in_pixel;
    if (issue)   rd_data_q      <= mem[rd_addr_q];
  end

  assign in_ready   = (state_q == S_FILL);
  assign frame_done = frame_done_q;
  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_last   = out_last_q;
  assign ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_conv_result_collector.sv
module tb_conv_result_collector;

  localparam int DW    = 8;
  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
  localparam int AW    = 12;
  localparam int N     = IMG_W * IMG_H;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_pixel;
  logic          in_ready;
  logic          frame_done;
  logic          dump_start;
  logic          out_valid;
  logic [DW-1:0] out_pixel;
  logic          out_ready;
  logic          out_last;
  logic          ovf_err;

  int total;
  int bad;

  conv_result_collector #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .frame_done (frame_done),
    .dump_start (dump_start),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle-level vector, applied before an edge and compared after it.
  typedef struct {
    logic       in_valid;
    logic [7:0] in_pixel;
    logic       dump_start;
    logic       out_ready;
    logic       e_in_ready;
    logic       e_out_valid;
    logic [7:0] e_pixel;
    logic       e_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] expv(input int pmode, input int k);
    logic [31:0] kk;
    kk = k;
    return (pmode == 0) ? kk[7:0] : 8'h55;
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_pixel   = '0;
    dump_start = 1'b0;
    out_ready  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // pmode 0 = ramp (addr[7:0]), 1 = constant 0x55. One valid cycle in every gap.
  // ds_at >= 0 pulses dump_start with the beat of that index (must be ignored).
  task automatic fill(input int pmode, input int gap, input int ds_at);
    int acc, cyc, early, ov;
    acc = 0; cyc = 0; early = 0; ov = 0;
    while (acc < N && cyc < N * gap + 100) begin
      in_valid   = ((cyc % gap) == 0);
      in_pixel   = expv(pmode, acc);
      dump_start = (ds_at >= 0) && (acc == ds_at) && in_valid;
      if (in_valid && in_ready) acc++;
      step();
      cyc++;
      if (out_valid) ov++;
      if (frame_done && acc < N) early++;
    end
    in_valid   = 1'b0;
    dump_start = 1'b0;
    check("fill_accepted", acc, N);
    check("frame_done_at_last", frame_done, 1);
    check("frame_done_early", early, 0);
    check("out_valid_during_fill", ov, 0);
    check("in_ready_when_full", in_ready, 0);
    step();
    check("frame_done_single", frame_done, 0);
  endtask

  task automatic start_dump();
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    check("dump_lat_e0", out_valid, 0);
    step();
    check("dump_lat_e1", out_valid, 0);
    step();
    check("dump_lat_e2", out_valid, 1);
  endtask

  // rmode 1 = out_ready held high, 2 = random 50%. abort_at >= 0 resets mid-dump.
  task automatic drain(input int k0, input int pmode, input int rmode,
                       input int abort_at, input logic exp_ovf);
    int k, errs, bubbles, cyc, ovf_bad;
    logic prev_stall, done, aborted;
    logic [7:0] held;
    k = k0; errs = 0; bubbles = 0; cyc = 0; ovf_bad = 0;
    prev_stall = 1'b0; done = 1'b0; aborted = 1'b0; held = '0;
    while (!done && cyc < 4 * N + 100) begin
      if (prev_stall && (!out_valid || out_pixel !== held)) errs++;
      if (out_valid) begin
        if (out_pixel !== expv(pmode, k)) errs++;
        if (out_last !== (k == N - 1)) errs++;
      end else if (rmode == 1) begin
        bubbles++;
      end
      if (ovf_err !== exp_ovf) ovf_bad++;
      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_pixel", out_pixel, 0);
        aborted = 1'b1;
        break;
      end
      out_ready  = (rmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      prev_stall = out_valid && !out_ready;
      held       = out_pixel;
      if (out_valid && out_ready) begin
        if (out_last) done = 1'b1;
        k++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    check("dump_errors", errs, 0);
    if (aborted) begin
      step();
      rst_n = 1'b1;
      step();
      check("abort_ovf_clear", ovf_err, 0);
      check("abort_in_ready_after", in_ready, 1);
    end else begin
      check("dump_count", k, N);
      check("ovf_during_dump", ovf_bad, 0);
      if (rmode == 1) check("dump_bubbles", bubbles, 0);
      check("post_dump_out_valid", out_valid, 0);
      check("post_dump_in_ready", in_ready, 1);
    end
  endtask

  vec_t vecs[9];

  initial begin
    total = 0;
    bad   = 0;

    // Starts in FULL with a ramp stored: overflow, then dump with early stalls.
    vecs[0] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1};
    vecs[8] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_pixel   = '0;
    dump_start = 1'b0;
    out_ready  = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_done", frame_done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pixel", out_pixel, 0);
    check("rst_out_last", out_last, 0);
    check("rst_ovf_err", ovf_err, 0);
    do_reset();

    // Ramp fill, full-rate dump.
    fill(0, 1, -1);
    start_dump();
    drain(0, 0, 1, -1, 1'b0);

    // Ramp fill, randomly stalled dump.
    fill(0, 1, -1);
    start_dump();
    drain(0, 0, 2, -1, 1'b0);

    // Overflow while full, then a dump with hand-stepped stalls.
    fill(0, 1, -1);
    for (int i = 0; i < 9; i++) begin
      in_valid   = vecs[i].in_valid;
      in_pixel   = vecs[i].in_pixel;
      dump_start = vecs[i].dump_start;
      out_ready  = vecs[i].out_ready;
      step();
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_out_valid);
      check($sformatf("vec%0d_ovf", i), ovf_err, vecs[i].e_ovf);
      check($sformatf("vec%0d_out_last", i), out_last, 0);
      if (vecs[i].e_out_valid)
        check($sformatf("vec%0d_pixel", i), out_pixel, vecs[i].e_pixel);
    end
    in_valid   = 1'b0;
    dump_start = 1'b0;
    out_ready  = 1'b0;
    drain(3, 0, 1, -1, 1'b1);
    check("ovf_after_dump", ovf_err, 1);

    do_reset();
    check("ovf_cleared_by_reset", ovf_err, 0);

    // dump_start during FILL is ignored; then reset mid-dump at beat 1000.
    fill(0, 1, 100);
    start_dump();
    drain(0, 0, 1, 1000, 1'b0);

    // Gapped refill of 0x55 after the abort, then a full dump.
    fill(1, 3, -1);
    start_dump();
    drain(0, 1, 1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
